// File: rtl/fsm_cmd_pkg.sv
// Shared types and constants for the command filter in front of the 2-bit control FSM.
package fsm_cmd_pkg;

    localparam int IN_W          = 3;  // raw user request width
    localparam int CMD_W         = 2;  // command width = FSM state width
    localparam int LEGAL_MAX_DEF = 3;  // default highest legal command code

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        LOCKOUT = 2'd2
    } fsm_cmd_state_t;

endpackage

// File: rtl/fsm_cmd_filter_input_stabilizer.sv
// Samples the raw request every cycle and reports when it has held steady long enough
// to become a candidate. Frozen while the filter is locked out.
module input_stabilizer #(
    parameter int W             = 3,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         freeze,
    input  logic         clear,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable_val,
    output logic         stable_hit
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1) < 1 ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 1);

    logic [W-1:0]     r_in;
    logic [CNT_W-1:0] stab_cnt;

    // Register the request and count how long it has stayed unchanged.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it lives inside the clocked block and only
        // takes effect on a rising edge; all state here uses non-blocking assignment.
        if (!rst_n) begin
            r_in     <= '0;
            stab_cnt <= '0;
        end else if (!freeze) begin
            r_in <= raw;
            if (raw != r_in || clear)
                stab_cnt <= '0;
            else if (stab_cnt != CNT_MAX)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    assign stable_val = r_in;
    assign stable_hit = (stab_cnt == CNT_HIT) && (raw == r_in);

endmodule

// File: rtl/fsm_cmd_filter.sv
// Guard stage for the 2-bit control FSM: debounces the user request, rejects illegal
// codes, issues changed legal values over valid/ready, and locks out after repeated
// rejections. Optional odd-parity check on the request is enabled by FSM_CMD_PARITY_EN.
module fsm_cmd_filter
    import fsm_cmd_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int LEGAL_MAX     = LEGAL_MAX_DEF,
    parameter int ERR_LIMIT     = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [IN_W-1:0]                    user_input,
`ifdef FSM_CMD_PARITY_EN
    input  logic                               user_parity,
`endif
    input  logic                               cmd_ready,
    output logic                               cmd_valid,
    output logic [CMD_W-1:0]                   cmd_data,
    output logic                               err_pulse,
    output logic [$clog2(ERR_LIMIT+1)-1:0]     err_count,
    output logic                               locked
);

    localparam int ERR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_LIMIT);

`ifdef FSM_CMD_PARITY_EN
    localparam int SW = IN_W + 1;
`else
    localparam int SW = IN_W;
`endif

    fsm_cmd_state_t   state;
    logic [CMD_W-1:0] last_cmd;
    logic [SW-1:0]    raw;
    logic [SW-1:0]    stable_val;
    logic             stable_hit;
    logic [IN_W-1:0]  cand_val;
    logic             legal;
    logic             candidate;
    logic             handshake;
    logic             stab_clear;
    logic             freeze;
    logic [ERR_W-1:0] err_inc;

`ifdef FSM_CMD_PARITY_EN
    // Parity bit rides with the value so a parity change also restarts stabilisation.
    assign raw   = {user_parity, user_input};
    assign legal = (int'(cand_val) <= LEGAL_MAX) && (^stable_val);
`else
    assign raw   = user_input;
    assign legal = (int'(cand_val) <= LEGAL_MAX);
`endif

    assign cand_val   = stable_val[IN_W-1:0];
    assign candidate  = stable_hit && (cand_val != {1'b0, last_cmd});
    assign handshake  = cmd_valid && cmd_ready;
    assign freeze     = (state == LOCKOUT);
    // A rejection restarts the count so a held illegal value is re-flagged only after
    // another full stable window; a handshake restarts it so the next value is fresh.
    assign stab_clear = ((state == IDLE) && candidate && !legal) ||
                        ((state == ISSUE) && handshake);
    assign err_inc    = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;

    input_stabilizer #(
        .W             (SW),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clk        (clk),
        .rst_n      (rst_n),
        .freeze     (freeze),
        .clear      (stab_clear),
        .raw        (raw),
        .stable_val (stable_val),
        .stable_hit (stable_hit)
    );

    // Command FSM with registered handshake, error and lockout outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_cmd  <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
            locked    <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (candidate) begin
                        if (legal) begin
                            state     <= ISSUE;
                            cmd_data  <= cand_val[CMD_W-1:0];
                            cmd_valid <= 1'b1;
                        end else begin
                            err_pulse <= 1'b1;
                            err_count <= err_inc;
                            if (err_inc == ERR_MAX) begin
                                state  <= LOCKOUT;
                                locked <= 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (handshake) begin
                        last_cmd  <= cmd_data;
                        cmd_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                LOCKOUT: begin
                    cmd_valid <= 1'b0;
                    locked    <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fsm_cmd_filter.md
Name: fsm_cmd_filter

Overview:
Upstream guard stage for the 2-bit-state control FSM. It samples the raw 3-bit user_input, requires the value to hold steady before accepting it, and rejects codes outside the FSM's legal state range. Each accepted, changed value is issued to the FSM as a 2-bit command over a valid/ready handshake. Repeated illegal requests lock the path until reset, so no unvalidated value ever reaches the FSM state register.

Parameters:
STABLE_CYCLES, 4, consecutive cycles the sampled input must hold unchanged before it is a candidate (min 1)
LEGAL_MAX, 3, highest legal command code; candidates above this are illegal
ERR_LIMIT, 3, illegal-candidate count that forces lockout (min 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
user_input  input  3  raw user request
cmd_ready  input  1  downstream FSM accepts the command this cycle
cmd_valid  output  1  command available
cmd_data  output  2  accepted command code, i.e. the target FSM state
err_pulse  output  1  one-cycle pulse per rejected candidate
err_count  output  $clog2(ERR_LIMIT+1)  saturating count of rejections
locked  output  1  lockout active

Behaviour:
- Reset: rst_n is sampled low on a rising edge (synchronous, active-low). All outputs are 0, state is IDLE, stab_cnt is 0, r_in is 0, and last_cmd is 0 (matches the FSM reset state 0).
- r_in <= user_input every cycle, except in LOCKOUT.
- stab_cnt: cleared when user_input != r_in; otherwise increments, saturating at STABLE_CYCLES.
- A candidate exists when stab_cnt == STABLE_CYCLES-1, r_in is unchanged, and r_in != {1'b0,last_cmd}. A value equal to last_cmd is never reissued.
- State machine: IDLE, ISSUE, LOCKOUT.
- IDLE, legal candidate (r_in <= LEGAL_MAX): next state ISSUE; cmd_data <= r_in[1:0]; cmd_valid <= 1.
- IDLE, illegal candidate:
  - err_pulse <= 1 for one cycle.
  - err_count increments, saturating.
  - If the incremented count == ERR_LIMIT, go to LOCKOUT and set locked <= 1 in the same cycle as err_pulse. Otherwise stay in IDLE.
  - stab_cnt clears, so a held illegal value is re-flagged only after another STABLE_CYCLES.
- ISSUE:
  - cmd_valid and cmd_data stay stable until cmd_valid && cmd_ready.
  - Input changes are sampled but never alter cmd_data.
  - On handshake: last_cmd <= cmd_data, cmd_valid <= 0, stab_cnt <= 0, return to IDLE.
- LOCKOUT: cmd_valid is 0 and locked is 1. Inputs are ignored. Exit only by reset.
- Latency: new value on user_input before edge 0, held -> cmd_valid high after edge STABLE_CYCLES+1 (5 edges at default). With cmd_ready held high, the handshake completes on the edge after cmd_valid rises.
- Value changes every cycle: stab_cnt never reaches threshold, so no command and no error.
- Reset mid-ISSUE: cmd_valid falls on that edge and no handshake is recorded.

Optional Feature:
FSM_CMD_PARITY_EN
- Defined: adds input user_parity (1 bit), registered alongside r_in. A candidate is legal only if it is in range and ^{r_in,r_par} == 1 (odd parity). A parity failure is treated exactly like an out-of-range code.
- Undefined: no user_parity port and no parity check.

Decomposition:
- Package fsm_cmd_pkg:
  - IN_W=3, CMD_W=2.
  - Enum typedef fsm_cmd_state_t {IDLE, ISSUE, LOCKOUT}.
  - Default LEGAL_MAX.
- Sub-module input_stabilizer: holds r_in and stab_cnt (parameter STABLE_CYCLES) and outputs stable_val and stable_hit. fsm_cmd_filter holds the state machine, legality check, error counter and handshake.

Test Plan:
- Reset, then user_input=3'd2 held, cmd_ready=1 -> cmd_valid rises after edge 5, cmd_data=2; handshake on the next edge; last_cmd=2; no reissue while 2 is held.
- user_input=3'd1 held, cmd_ready=0 for 10 cycles, then user_input=3'd3 -> cmd_data stays 1 until cmd_ready=1.
- user_input=3'd6 held 12 cycles -> err_pulse at edges 5 and 9; err_count=2; no cmd_valid.
- Three rejections of 3'd7 -> the third err_pulse coincides with locked=1; a later legal 3'd1 yields no cmd_valid; rst_n low for one edge clears locked and err_count.
- user_input toggles 0/1 every cycle for 20 cycles -> no cmd_valid, no err_pulse.
- With FSM_CMD_PARITY_EN: user_input=3'd1 with user_parity=1 (even total) -> err_pulse; with user_parity=0 -> cmd_data=1 issued.
